uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entries; the block SHALL support only powers of two, 2..256.
REQ-002 Parameter AW, default 4, meaning pointer width; the block SHALL require AW = log2(DEPTH).
REQ-003 The block SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL provide port in_valid, input, 1 bit: UART rd_rdy, a single-cycle pulse per received byte.
REQ-006 The block SHALL provide port in_data, input, 8 bits: UART dout, valid when in_valid=1.
REQ-007 The block SHALL provide port uart_rd_en, output, 1 bit: drives UART rd_en; high while the FIFO can accept a byte.
REQ-008 The block SHALL provide port rd_en, input, 1 bit: consumer pop request.
REQ-009 The block SHALL provide port dout, output, 8 bits: head-of-FIFO byte (first-word fall-through).
REQ-010 The block SHALL provide port empty, output, 1 bit: FIFO holds zero entries.
REQ-011 The block SHALL provide port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-012 The block SHALL provide port count, output, AW+1 bits: current occupancy, 0..DEPTH.
REQ-013 The block SHALL provide port overflow, output, 1 bit: sticky flag, set when a byte is dropped.
REQ-014 The block SHALL provide port clr_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-015 Storage SHALL be a DEPTH x 8 array with wr_ptr and rd_ptr (AW bits each, wrapping DEPTH-1 -> 0) and a count register (AW+1 bits).
REQ-016 A push SHALL occur on a rising edge when in_valid=1 and (full=0 or a pop occurs in the same cycle); it writes in_data at wr_ptr and then increments wr_ptr.
REQ-017 A pop SHALL occur on a rising edge when rd_en=1 and empty=0; it increments rd_ptr.
REQ-018 rd_en while empty SHALL be ignored, with no pointer, count or flag change.
REQ-019 Count SHALL be updated as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-020 When full and in_valid=1 and rd_en=1, the push and the pop SHALL both occur and count SHALL remain DEPTH.
REQ-021 When empty and in_valid=1 and rd_en=1, the pop SHALL be ignored, the push SHALL occur, and count SHALL become 1.
REQ-022 When in_valid=1 and full=1 and rd_en=0, the byte SHALL be dropped and overflow SHALL be set on that edge; FIFO contents SHALL be unchanged.
REQ-023 overflow SHALL clear on an edge with clr_ovf=1; if a drop occurs in the same cycle, set SHALL win.
REQ-024 dout SHALL equal mem[rd_ptr] combinationally, with no read latency; dout SHALL be don't-care while empty=1.
REQ-025 Latency: a byte pushed at edge N SHALL appear on dout and deassert empty after edge N, i.e. readable in cycle N+1.
REQ-026 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH), both derived from registered count.
REQ-027 uart_rd_en SHALL equal ~full, so the UART is enabled to deliver whenever space exists.
REQ-028 in_valid pulses arriving on consecutive cycles SHALL each be accepted, giving 1 byte/cycle throughput.

Reset
REQ-029 While rst=1, independent of clk: wr_ptr=0, rd_ptr=0, count=0, overflow=0, empty=1, full=0, uart_rd_en=1.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored bytes.
REQ-032 The first push SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 The bench SHALL cover: reset, then push 0xE8 -> empty=0, count=1, dout=0xE8 next cycle; then pop -> empty=1, count=0.
REQ-034 The bench SHALL cover: push 16 bytes 0x00..0x0F at DEPTH=16 -> full=1, uart_rd_en=0; 16 pops return 0x00..0x0F in order.
REQ-035 The bench SHALL cover: full, then push 0xAA with rd_en=0 -> overflow=1, count=16, subsequent pop order unchanged; then clr_ovf=1 -> overflow=0.
REQ-036 The bench SHALL cover: full with simultaneous push 0x55 and pop -> count stays 16, 0x55 becomes the last byte read.
REQ-037 The bench SHALL cover: 40 push/pop pairs interleaved across pointer wrap -> data matches the scoreboard and count never exceeds 16.
REQ-038 The bench SHALL cover: two uart instances linked tx->rx, u1 sends 0xCA -> FIFO on u2 holds 0xCA, count=1; rst asserted mid-frame -> count=0, empty=1 immediately.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between a UART receiver, the RX FIFO and its consumer.
//   master : producer/consumer side (drives in_valid, in_data, rd_en, clr_ovf)
//   slave  : FIFO side (drives uart_rd_en, dout, empty, full, count, overflow)
interface uart_rx_fifo_if #(
  parameter int unsigned AW = 4
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          uart_rd_en;
  logic          rd_en;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_ovf;

  modport master (
    output in_valid, in_data, rd_en, clr_ovf,
    input  uart_rd_en, dout, empty, full, count, overflow
  );

  modport slave (
    input  in_valid, in_data, rd_en, clr_ovf,
    output uart_rd_en, dout, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART: buffers bytes delivered as single-cycle
// in_valid pulses, first-word fall-through read side, sticky overflow flag.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   bus.in_valid/in_data : byte strobe and data from UART (rd_rdy/dout)
//   bus.uart_rd_en   : high while a byte can be accepted (~full)
//   bus.rd_en        : consumer pop request; bus.dout is the head byte
//   bus.empty/full/count : occupancy status from the registered count
//   bus.overflow     : sticky drop flag, cleared by bus.clr_ovf
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);

  if ((DEPTH < 2) || (DEPTH > 256) || (DEPTH != (1 << AW))) begin : g_bad_param
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..256 with AW = log2(DEPTH)");
  end

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;

  logic empty_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  // Status flags and transfer qualifiers; a pop frees a slot for a same-cycle push.
  always_comb begin
    empty_c = (count_q == '0);
    full_c  = (count_q == (AW+1)'(DEPTH));
    pop_c   = bus.rd_en && !empty_c;
    push_c  = bus.in_valid && (!full_c || pop_c);
    drop_c  = bus.in_valid && !push_c;
  end

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (pop_c && !push_c) begin
        count_q <= count_q - (AW+1)'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = mem[rd_ptr];
  assign bus.empty      = empty_c;
  assign bus.full       = full_c;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.uart_rd_en = !full_c;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference FIFO decides
// what each cycle should do, popped bytes go to a scoreboard queue, and an
// independent monitor compares dout whenever the DUT performs a pop.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BIT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_q   [$];
  logic       ovf_m = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every DUT pop must return the next expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && bus.rd_en && !bus.empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", bus.dout, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", int'(bus.dout), int'(e));
      end
    end
  end

  // Simple serial link standing in for a UART transmitter/receiver pair.
  logic       txd = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_busy = 1'b0;
      rx_cnt  = 0;
    end else if (!rx_busy) begin
      if (txd == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      for (int j = 0; j < 8; j++) begin
        if (rx_cnt == BIT * (j + 1) + BIT / 2) rx_byte[j] = txd;
      end
      if (rx_cnt == BIT * 9 + BIT / 2) begin
        rx_busy = 1'b0;
        rx_done = txd;
      end
    end
  end

  task automatic uart_tx(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      txd = frame[i];
      repeat (BIT) @(posedge clk);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"}, int'(bus.count), n);
    chk({tag, ".empty"}, int'(bus.empty), int'(n == 0));
    chk({tag, ".full"}, int'(bus.full), int'(n == DEPTH));
    chk({tag, ".uart_rd_en"}, int'(bus.uart_rd_en), int'(n != DEPTH));
    chk({tag, ".overflow"}, int'(bus.overflow), int'(ovf_m));
    if (n > 0) chk({tag, ".dout"}, int'(bus.dout), int'(model_q[0]));
  endtask

  // One clock of stimulus; the reference decides push/pop/drop from occupancy.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c,
                      input string tag);
    int   n;
    logic pop_m;
    logic push_m;
    logic [7:0] tmp;
    n      = model_q.size();
    pop_m  = r && (n > 0);
    push_m = v && ((n < DEPTH) || pop_m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_en    = r;
    bus.clr_ovf  = c;
    if (pop_m) exp_q.push_back(model_q[0]);
    @(posedge clk);
    #1;
    if (pop_m) tmp = model_q.pop_front();
    if (push_m) model_q.push_back(d);
    if (v && !push_m) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    check_state(tag);
  endtask

  task automatic reset_model();
    model_q.delete();
    exp_q.delete();
    ovf_m = 1'b0;
  endtask

  initial begin
    int guard;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;

    // Reset values while rst is held, before any clock edge.
    #1;
    check_state("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single byte in and out; first push right after reset release.
    step(1'b1, 8'hE8, 1'b0, 1'b0, "push_e8");
    step(1'b0, 8'h00, 1'b1, 1'b0, "pop_e8");
    step(1'b0, 8'h00, 1'b1, 1'b0, "pop_empty");
    step(1'b1, 8'h3C, 1'b1, 1'b0, "push_pop_empty");
    step(1'b0, 8'h00, 1'b1, 1'b0, "drain_3c");

    // Fill with 0x00..0x0F back to back, then overflow handling.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    step(1'b1, 8'hAA, 1'b0, 1'b0, "drop_aa");
    step(1'b1, 8'hAB, 1'b0, 1'b1, "drop_and_clear");
    step(1'b0, 8'h00, 1'b0, 1'b0, "idle_full");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "fill2");
    step(1'b1, 8'h55, 1'b1, 1'b0, "full_push_pop");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

    // Interleaved push/pop pairs across pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "prefill");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0, "pair_push");
      step(1'b0, 8'h00, 1'b1, 1'b0, "pair_pop");
      chk("pair_count_bound", int'(bus.count <= (AW+1)'(DEPTH)), 1);
    end

    // Random traffic biased toward filling, then toward draining.
    for (int i = 0; i < 300; i++) begin
      step(1'b1 & ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), "rand_fill");
    end
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), "rand_drain");
    end
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, "final_drain");

    // Serial link delivers 0xCA into the FIFO.
    rx_done = 1'b0;
    uart_tx(8'hCA);
    guard = 0;
    while (!rx_done && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    chk("link_rx_done", int'(rx_done), 1);
    #1;
    step(1'b1, rx_byte, 1'b0, 1'b0, "link_push");
    chk("link_byte", int'(bus.dout), 8'hCA);
    chk("link_count", int'(bus.count), 1);

    // Reset in the middle of the next frame discards everything at once.
    step(1'b1, 8'h11, 1'b0, 1'b0, "pre_rst_push");
    txd = 1'b0;
    repeat (BIT * 3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    reset_model();
    check_state("mid_rst");
    txd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0, "post_rst_push");
    step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_pop");

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
